inst_fetch: RTL and testbench

//  Initiator side of the instruction-ROM read interface. Owns the PC and drives rom_ce/rom_addr.

---
 rtl/inst_fetch_pkg.sv | 18 +
 rtl/inst_fetch_if_id_reg.sv | 61 ++++++
 rtl/inst_fetch_pc_reg.sv | 54 +++++
 rtl/inst_fetch.sv | 71 +++++++
 tb/tb_inst_fetch.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch slice.
//   chip_en_e       : ROM chip-enable encoding
//   is_misaligned() : word-alignment test on the low two bits of a byte address
package inst_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  typedef enum logic {
    CHIP_DISABLE = 1'b0,
    CHIP_ENABLE  = 1'b1
  } chip_en_e;

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return |addr_lo;
  endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register with flush, hold and bubble handling.
//   ce                 : fetch issued this cycle (latch only when set)
//   stall_if, stall_id : stall controls
//   flush              : kill IF/ID content
//   pc, inst           : current fetch address and ROM data
//   id_pc, id_inst, id_valid, id_adel : registered IF/ID outputs
module inst_fetch_if_id_reg
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_W,
  parameter int unsigned DATA_W = INST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic              id_valid,
  output logic              id_adel
);

  logic adel;

  assign adel = is_misaligned(pc[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (flush) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else if (stall_id) begin
      id_pc    <= id_pc;
      id_inst  <= id_inst;
      id_valid <= id_valid;
      id_adel  <= id_adel;
    end else if (stall_if || !ce) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
      id_adel  <= 1'b0;
    end else begin
      // A misaligned fetch still issues but delivers a NOP tagged AdEL.
      id_pc    <= pc;
      id_inst  <= adel ? '0 : inst;
      id_valid <= 1'b1;
      id_adel  <= adel;
    end
  end

endmodule

// File: rtl/inst_fetch_pc_reg.sv
// Program counter, ROM chip enable and next-PC selection.
//   clk, rst_n          : clock, async active-low reset
//   stall_if            : hold PC
//   flush, flush_pc     : highest-priority redirect
//   branch_flag/target  : taken branch redirect (ignored while stalled)
//   rom_ce              : 0 in reset and for the first edge after release
//   pc                  : current fetch address (registered)
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_if,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] pc
);

  chip_en_e          ce_q;
  logic [ADDR_W-1:0] pc_next;

  always_comb begin
    pc_next = pc + ADDR_W'(4);
    if (flush) begin
      pc_next = flush_pc;
    end else if (stall_if) begin
      pc_next = pc;
    end else if (branch_flag) begin
      pc_next = branch_target;
    end
  end

  // PC only moves once the enable bit is set, so the first fetch after
  // release is always RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_q <= CHIP_DISABLE;
      pc   <= RESET_PC;
    end else if (ce_q == CHIP_DISABLE) begin
      ce_q <= CHIP_ENABLE;
    end else begin
      pc <= pc_next;
    end
  end

  assign rom_ce = (ce_q == CHIP_ENABLE);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the combinational ROM and
// registers the fetched instruction into IF/ID.
//   clk, rst_n                  : clock, async active-low reset
//   stall_if, stall_id          : stall controls
//   flush, flush_pc             : exception/eret redirect
//   branch_flag, branch_target  : taken branch redirect (delay-slot semantics)
//   rom_ce, rom_addr, rom_inst  : ROM interface (rom_addr = PC)
//   id_pc, id_inst, id_valid, id_adel : IF/ID outputs
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = INST_ADDR_W,
  parameter int unsigned       DATA_W   = INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic              id_valid,
  output logic              id_adel
);

  logic [ADDR_W-1:0] pc;

  inst_fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_if      (stall_if),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .rom_ce        (rom_ce),
    .pc            (pc)
  );

  // pc sits at RESET_PC whenever rom_ce is low, so no mux is needed here.
  assign rom_addr = pc;

  inst_fetch_if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .ce       (rom_ce),
    .stall_if (stall_if),
    .stall_id (stall_id),
    .flush    (flush),
    .pc       (pc),
    .inst     (rom_inst),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid),
    .id_adel  (id_adel)
  );

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall_if;
  logic        stall_id;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_adel;

  int unsigned n_cmp;
  int unsigned n_err;

  // Reference model state: what a fetch stage should present, per the rules
  logic        m_started;
  logic [31:0] m_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  logic        m_id_valid;
  logic        m_id_adel;

  inst_fetch #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid),
    .id_adel       (id_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: inst_mem[i] = 32'h1000_0000 + i, word-indexed
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign rom_inst = rom_word(rom_addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".rom_ce"},   {31'd0, rom_ce},   {31'd0, m_started});
    check_eq({tag, ".rom_addr"}, rom_addr,          m_pc);
    check_eq({tag, ".id_pc"},    id_pc,             m_id_pc);
    check_eq({tag, ".id_inst"},  id_inst,           m_id_inst);
    check_eq({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_id_valid});
    check_eq({tag, ".id_adel"},  {31'd0, id_adel},  {31'd0, m_id_adel});
  endtask

  task automatic model_clear();
    m_started  = 1'b0;
    m_pc       = 32'h0;
    m_id_pc    = 32'h0;
    m_id_inst  = 32'h0;
    m_id_valid = 1'b0;
    m_id_adel  = 1'b0;
  endtask

  task automatic idle_inputs();
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    flush         = 1'b0;
    flush_pc      = 32'h0;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
  endtask

  // One clock: predict from pre-edge inputs, advance, compare.
  task automatic step(input string tag);
    logic        n_started;
    logic [31:0] n_pc, n_id_pc, n_id_inst;
    logic        n_id_valid, n_id_adel;
    n_started  = 1'b1;
    n_pc       = m_pc;
    n_id_pc    = m_id_pc;
    n_id_inst  = m_id_inst;
    n_id_valid = m_id_valid;
    n_id_adel  = m_id_adel;
    if (m_started) begin
      if (flush || (stall_if && !stall_id)) begin
        n_id_pc = 32'h0; n_id_inst = 32'h0; n_id_valid = 1'b0; n_id_adel = 1'b0;
      end else if (!stall_id) begin
        n_id_pc    = m_pc;
        n_id_adel  = (m_pc % 4) != 0;
        n_id_inst  = n_id_adel ? 32'h0 : rom_word(m_pc);
        n_id_valid = 1'b1;
      end
      if (flush)            n_pc = flush_pc;
      else if (stall_if)    n_pc = m_pc;
      else if (branch_flag) n_pc = branch_target;
      else                  n_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    m_started  = n_started;
    m_pc       = n_pc;
    m_id_pc    = n_id_pc;
    m_id_inst  = n_id_inst;
    m_id_valid = n_id_valid;
    m_id_adel  = n_id_adel;
    check_all(tag);
  endtask

  // Assert reset away from the clock edge and confirm the async clear.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    check_all(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    model_clear();
    rst_n = 1'b0;
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // 1: release, first edge only enables, then sequential fetch
    step("release");
    step("seq0");
    check_eq("seq0.inst_const", id_inst, 32'h1000_0000);
    step("seq1");

    // 2: branch at pc=8 -> delay slot pc 8 delivered, then 0x40
    branch_flag = 1'b1; branch_target = 32'h40;
    step("br_slot");
    check_eq("br_slot.pc_const", id_pc, 32'h8);
    idle_inputs();
    step("br_tgt");
    check_eq("br_tgt.pc_const", id_pc, 32'h40);
    check_eq("br_tgt.inst_const", id_inst, 32'h1000_0010);

    // 3: stall_if only -> bubbles, held pc delivered once
    stall_if = 1'b1;
    step("sif0");
    step("sif1");
    idle_inputs();
    step("sif_rel");
    step("sif_next");

    // 4: full stall -> frozen, then lossless resume
    stall_if = 1'b1; stall_id = 1'b1;
    for (int i = 0; i < 3; i++) step("sall");
    idle_inputs();
    step("sall_rel");
    step("sall_next");

    // 5: flush wins over stall_if and branch
    flush = 1'b1; flush_pc = 32'h20; stall_if = 1'b1;
    branch_flag = 1'b1; branch_target = 32'h80;
    step("flush");
    check_eq("flush.valid_const", {31'd0, id_valid}, 32'd0);
    idle_inputs();
    step("flush_tgt");
    check_eq("flush_tgt.pc_const", id_pc, 32'h20);

    // 6: misaligned branch target -> AdEL with NOP
    branch_flag = 1'b1; branch_target = 32'h42;
    step("mis_slot");
    idle_inputs();
    step("mis");
    check_eq("mis.adel_const", {31'd0, id_adel}, 32'd1);
    check_eq("mis.inst_const", id_inst, 32'h0);
    step("mis_next");

    // PC wrap at top of address space
    flush = 1'b1; flush_pc = 32'hFFFF_FFF8;
    step("wrap_f");
    idle_inputs();
    for (int i = 0; i < 3; i++) step("wrap");

    // Reset mid-run then restart
    #3;
    pulse_reset("midrst");
    step("midrst_rel");
    step("midrst_seq");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      stall_if    = ($urandom_range(0, 5) == 0);
      stall_id    = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      branch_flag = ($urandom_range(0, 5) == 0);
      t = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 4) == 0) t[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) t = t | 32'hFFFF_FF00;
      branch_target = t;
      flush_pc      = {t[31:2] ^ 30'h15, t[1:0]};
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        step("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
